// File: rtl/verificare_cod_pkg.sv
// Shared definitions for the sequence-lock checker: symbol encoding,
// FSM state type and small compile-time helpers.
package pachet_cod;

    localparam int SYM_W = 3;

    // Symbol = {long, button[1:0]}, button in 1..3
    localparam logic [SYM_W-1:0] S1 = 3'b001;
    localparam logic [SYM_W-1:0] S2 = 3'b010;
    localparam logic [SYM_W-1:0] S3 = 3'b011;
    localparam logic [SYM_W-1:0] L1 = 3'b101;
    localparam logic [SYM_W-1:0] L2 = 3'b110;
    localparam logic [SYM_W-1:0] L3 = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_OK,
        ST_FAIL,
        ST_LOCK
    } stare_t;

    // Number of bits needed to hold values 0..max_val (at least 1).
    function automatic int latime(input int max_val);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= max_val) w = i + 1;
        end
        return w;
    endfunction

    function automatic int maxim(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Pulse index 0..2 = short 1..3, 3..5 = long 1..3.
    function automatic logic [SYM_W-1:0] simbol_index(input int k);
        logic [1:0] b;
        b = 2'(k % 3 + 1);
        return {(k >= 3), b};
    endfunction

endpackage

// File: rtl/verificare_cod_codificator.sv
// Turns the six press pulses of one cycle into a symbol plus flags.
// More than one pulse in a cycle still yields one symbol, marked bad.
module codificator_simbol
    import pachet_cod::*;
(
    input  logic [5:0]       puls_i,   // {lung_3, lung_2, lung_1, scurt_3, scurt_2, scurt_1}
    output logic             valid_o,
    output logic             bad_o,
    output logic [SYM_W-1:0] sym_o
);

    logic [2:0] nr_puls;

    // Count active pulses and pick the symbol of the highest active one
    always_comb begin
        nr_puls = '0;
        sym_o   = '0;
        for (int k = 0; k < 6; k++) begin
            if (puls_i[k]) begin
                nr_puls = nr_puls + 3'd1;
                sym_o   = simbol_index(k);
            end
        end
    end

    assign valid_o = (nr_puls != 3'd0);
    assign bad_o   = (nr_puls > 3'd1);

endmodule

// File: rtl/verificare_cod.sv
// Sequence-lock checker: collects LEN press symbols, compares them to CODE
// and reports open / wrong / lockout, with a consecutive-failure lockout.
module verificare_cod
    import pachet_cod::*;
#(
    parameter int                     LEN         = 4,
    parameter logic [LEN*SYM_W-1:0]   CODE        = 12'b001_101_010_111,
    parameter int                     TIMEOUT     = 1000,
    parameter int                     HOLD        = 200,
    parameter int                     MAX_FAIL    = 3,
    parameter int                     LOCK_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scurt_1,
    input  logic       scurt_2,
    input  logic       scurt_3,
    input  logic       lung_1,
    input  logic       lung_2,
    input  logic       lung_3,
    output logic       deschis,
    output logic       gresit,
    output logic       blocat,
    output logic       ocupat,
    output logic [3:0] nr_simb
);

    localparam int W  = LEN * SYM_W;
    localparam int TW = latime(maxim(maxim(HOLD, LOCK_CYCLES), TIMEOUT));
    localparam int FW = latime(MAX_FAIL);

    logic             ev_valid;
    logic             ev_bad;
    logic [SYM_W-1:0] ev_sym;

    stare_t           stare_q, stare_d;
    logic [W-1:0]     shift_q, shift_d;
    logic             bad_q, bad_d;
    logic [3:0]       nr_q, nr_d;
    logic [TW-1:0]    idle_q, idle_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [FW-1:0]    fail_q, fail_d;
    logic             esec;

    codificator_simbol u_cod (
        .puls_i  ({lung_3, lung_2, lung_1, scurt_3, scurt_2, scurt_1}),
        .valid_o (ev_valid),
        .bad_o   (ev_bad),
        .sym_o   (ev_sym)
    );

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stare_q <= ST_IDLE;
            shift_q <= '0;
            bad_q   <= 1'b0;
            nr_q    <= '0;
            idle_q  <= '0;
            timer_q <= '0;
            fail_q  <= '0;
        end else begin
            stare_q <= stare_d;
            shift_q <= shift_d;
            bad_q   <= bad_d;
            nr_q    <= nr_d;
            idle_q  <= idle_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
        end
    end

    // Next-state logic: collection, comparison, result hold and lockout
    always_comb begin
        stare_d = stare_q;
        shift_d = shift_q;
        bad_d   = bad_q;
        nr_d    = nr_q;
        idle_d  = idle_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        esec    = 1'b0;

        case (stare_q)
            ST_IDLE, ST_COLLECT: begin
                // A timeout beats a press arriving in the same cycle
                if (stare_q == ST_COLLECT && idle_q >= TW'(TIMEOUT)) begin
                    esec = 1'b1;
                end else if (ev_valid) begin
                    // Shift register is zero in IDLE, so the same shift
                    // serves as "store first symbol"
                    shift_d = (shift_q << SYM_W) | W'(ev_sym);
                    bad_d   = bad_q | ev_bad;
                    nr_d    = nr_q + 4'd1;
                    idle_d  = TW'(1);
                    stare_d = (nr_q + 4'd1 == 4'(LEN)) ? ST_CHECK : ST_COLLECT;
                end else if (stare_q == ST_COLLECT && idle_q < TW'(TIMEOUT)) begin
                    idle_d = idle_q + TW'(1);
                end
            end

            ST_CHECK: begin
                if (!bad_q && shift_q == CODE) begin
                    stare_d = ST_OK;
                    fail_d  = '0;
                    timer_d = '0;
                    nr_d    = '0;
                    shift_d = '0;
                    bad_d   = 1'b0;
                end else begin
                    esec = 1'b1;
                end
            end

            ST_OK, ST_FAIL: begin
                if (timer_q == TW'(HOLD - 1)) begin
                    stare_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_LOCK: begin
                if (timer_q == TW'(LOCK_CYCLES - 1)) begin
                    stare_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: stare_d = ST_IDLE;
        endcase

        // Failed entry (mismatch, bad symbol or timeout). The collected
        // symbols are dropped right away so the count reads 0 while the
        // result or lockout is shown.
        if (esec) begin
            timer_d = '0;
            nr_d    = '0;
            shift_d = '0;
            bad_d   = 1'b0;
            if (fail_q == FW'(MAX_FAIL - 1)) begin
                stare_d = ST_LOCK;
                fail_d  = '0;
            end else begin
                stare_d = ST_FAIL;
                fail_d  = fail_q + FW'(1);
            end
        end
    end

    assign deschis = (stare_q == ST_OK);
    assign gresit  = (stare_q == ST_FAIL);
    assign blocat  = (stare_q == ST_LOCK);
    assign ocupat  = (stare_q == ST_COLLECT) || (stare_q == ST_CHECK);
    assign nr_simb = nr_q;

endmodule

// File: tb/tb_verificare_cod.sv
// Randomized + directed bench for verificare_cod with a queue scoreboard.
module tb_verificare_cod;

    localparam int LEN         = 4;
    localparam int TIMEOUT     = 40;
    localparam int HOLD        = 12;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYCLES = 150;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] puls = '0;   // 0..2 scurt_1..3, 3..5 lung_1..3
    logic       deschis, gresit, blocat, ocupat;
    logic [3:0] nr_simb;

    verificare_cod #(
        .LEN(LEN), .CODE(12'b001_101_010_111), .TIMEOUT(TIMEOUT),
        .HOLD(HOLD), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clock(clk), .reset(reset),
        .scurt_1(puls[0]), .scurt_2(puls[1]), .scurt_3(puls[2]),
        .lung_1(puls[3]), .lung_2(puls[4]), .lung_3(puls[5]),
        .deschis(deschis), .gresit(gresit), .blocat(blocat),
        .ocupat(ocupat), .nr_simb(nr_simb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference: the correct sequence as presses, and the failure streak
    logic [2:0] code_sym [4] = '{3'b001, 3'b101, 3'b010, 3'b111};
    int fails_m = 0;

    typedef struct { int kind; int rise; } exp_t;   // kind 0 open, 1 wrong, 2 locked
    exp_t exp_q[$];

    logic [2:0] seq  [8];
    int         gaps [8];

    function automatic string nume(input int k);
        return (k == 0) ? "deschis" : (k == 1) ? "gresit" : "blocat";
    endfunction

    // Monitor: pop expected result on each rising output, check pulse length on fall
    logic [2:0] prev = '0;
    int rise_c [3];
    always @(negedge clk) begin
        logic [2:0] now;
        exp_t e;
        int dur, req;
        now = {blocat, gresit, deschis};
        if (reset) begin
            prev = '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (now[k] && !prev[k]) begin
                    rise_c[k] = cyc;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rise: %s rose at cycle %0d, required no result", nume(k), cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != k || e.rise != cyc) begin
                            errors++;
                            $display("FAIL result: got %s at cycle %0d, required %s at cycle %0d",
                                     nume(k), cyc, nume(e.kind), e.rise);
                        end else begin
                            $display("result %s at cycle %0d ok", nume(k), cyc);
                        end
                    end
                end
                if (!now[k] && prev[k]) begin
                    dur = cyc - rise_c[k];
                    req = (k == 2) ? LOCK_CYCLES : HOLD;
                    checks++;
                    if (dur != req) begin
                        errors++;
                        $display("FAIL %s_length: high %0d cycles, required %0d", nume(k), dur, req);
                    end
                end
            end
            prev = now;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Drive one press for one cycle; dbl adds a second, different button
    task automatic press(input logic [2:0] s, input bit dbl);
        int idx, idx2;
        idx  = (s[2] ? 3 : 0) + int'(s[1:0]) - 1;
        puls = '0;
        puls[idx] = 1'b1;
        if (dbl) begin
            idx2 = (idx + 1 + int'($urandom_range(0, 4))) % 6;
            puls[idx2] = 1'b1;
        end
        tick;
        puls = '0;
    endtask

    function automatic logic [2:0] rand_sym;
        int k;
        k = int'($urandom_range(0, 5));
        return {(k >= 3), 2'(k % 3 + 1)};
    endfunction

    // Enter n presses from seq/gaps; a gap >= TIMEOUT means that press collides with the timeout
    task automatic run_entry(input int n, input int bad_idx);
        int  last, ev, kind, rise;
        bit  timed_out, ok;
        exp_t e;
        timed_out = 0;
        last = cyc;
        for (int i = 0; i < n; i++) begin
            for (int g = 1; g < gaps[i]; g++) tick;
            ev = cyc;
            if (i > 0 && gaps[i] >= TIMEOUT) begin
                timed_out = 1;
                press(seq[i], 0);
                check("ocupat_after_timeout", int'(ocupat), 0);
                break;
            end
            press(seq[i], i == bad_idx);
            last = ev;
            check("nr_simb_step", int'(nr_simb), i + 1);
            check("ocupat_collect", int'(ocupat), 1);
        end
        if (timed_out || n < LEN) begin
            ok   = 0;
            rise = last + TIMEOUT + 1;
        end else begin
            ok = (bad_idx < 0);
            for (int i = 0; i < LEN; i++) if (seq[i] != code_sym[i]) ok = 0;
            rise = last + 2;
        end
        if (ok) begin
            kind = 0;
            fails_m = 0;
        end else begin
            fails_m++;
            if (fails_m >= MAX_FAIL) begin
                kind = 2;
                fails_m = 0;
            end else begin
                kind = 1;
            end
        end
        e.kind = kind;
        e.rise = rise;
        exp_q.push_back(e);
        $display("entry n=%0d bad=%0d last=%0d -> expect %s at %0d", n, bad_idx, last, nume(kind), rise);
    endtask

    // Wait for the pending result to finish, poking buttons while it is shown
    task automatic wait_done;
        int budget;
        bit lk;
        budget = LOCK_CYCLES + TIMEOUT + HOLD + 20;
        while (budget > 0 && (exp_q.size() != 0 || deschis || gresit || blocat)) begin
            if (cyc % 7 == 0 && (deschis || gresit || blocat)) begin
                lk = blocat;
                press(rand_sym(), 0);
                check("ocupat_ignored", int'(ocupat), 0);
                if (lk) check("nr_simb_lock", int'(nr_simb), 0);
            end else begin
                tick;
            end
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL wait_result: %0d results still pending at cycle %0d, required 0", exp_q.size(), cyc);
            exp_q.delete();
        end
        tick;
        tick;
        check("nr_simb_idle", int'(nr_simb), 0);
        check("ocupat_idle", int'(ocupat), 0);
    endtask

    task automatic set_seq(input logic [2:0] a, b, c, d, input int gap);
        seq[0] = a; seq[1] = b; seq[2] = c; seq[3] = d;
        gaps[0] = 1; gaps[1] = gap; gaps[2] = gap; gaps[3] = gap;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_deschis"}, int'(deschis), 0);
        check({tag, "_gresit"},  int'(gresit), 0);
        check({tag, "_blocat"},  int'(blocat), 0);
        check({tag, "_ocupat"},  int'(ocupat), 0);
        check({tag, "_nr_simb"}, int'(nr_simb), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;
        reset = 1'b1;
        repeat (3) tick;
        check_reset_vals("reset");
        reset = 1'b0;
        tick;

        // Correct code, 10 cycles apart
        set_seq(3'b001, 3'b101, 3'b010, 3'b111, 10);
        run_entry(4, -1); wait_done;
        // Wrong code
        set_seq(3'b001, 3'b001, 3'b010, 3'b111, 10);
        run_entry(4, -1); wait_done;
        // Two symbols then silence: timeout
        set_seq(3'b001, 3'b101, 3'b010, 3'b111, 6);
        run_entry(2, -1); wait_done;
        // Third failure in a row: lockout
        set_seq(3'b011, 3'b101, 3'b010, 3'b111, 3);
        run_entry(4, -1); wait_done;
        // Press in the very cycle the timeout fires is dropped
        set_seq(3'b001, 3'b101, 3'b010, 3'b111, 5);
        gaps[2] = TIMEOUT;
        run_entry(3, -1); wait_done;
        // Longest accepted gap, correct code
        set_seq(3'b001, 3'b101, 3'b010, 3'b111, TIMEOUT - 1);
        run_entry(4, -1); wait_done;
        // Simultaneous presses on the first symbol, rest correct
        set_seq(3'b001, 3'b101, 3'b010, 3'b111, 8);
        run_entry(4, 0); wait_done;

        // Reset mid-entry clears everything, including the failure streak
        set_seq(3'b001, 3'b101, 3'b010, 3'b111, 4);
        for (int i = 0; i < 3; i++) begin
            for (int g = 1; g < gaps[i]; g++) tick;
            press(seq[i], 0);
        end
        check("nr_simb_before_reset", int'(nr_simb), 3);
        reset = 1'b1;
        #2;
        check_reset_vals("midreset");
        tick;
        reset = 1'b0;
        fails_m = 0;
        tick;
        set_seq(3'b010, 3'b101, 3'b010, 3'b111, 5);
        run_entry(4, -1); wait_done;
        run_entry(4, -1); wait_done;
        set_seq(3'b001, 3'b101, 3'b010, 3'b111, 5);
        run_entry(4, -1); wait_done;

        // Random entries
        for (int t = 0; t < 30; t++) begin
            n   = ($urandom_range(0, 99) < 85) ? LEN : int'($urandom_range(1, LEN - 1));
            bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            for (int i = 0; i < LEN; i++) begin
                seq[i]  = rand_sym();
                gaps[i] = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(1, TIMEOUT - 1));
            end
            if ($urandom_range(0, 9) < 4) for (int i = 0; i < LEN; i++) seq[i] = code_sym[i];
            run_entry(n, bad);
            wait_done;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
